pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Stall/flush controller for the D->E boundary of the 5-stage MIPS pipeline. Detects D-stage
//   RAW hazards (Tuse/Tnew), sequences the mult/div busy window, and drives PC/IF-ID enables
//   plus the ID/EX bubble-insert (clear) control. Also keeps a stall-cycle performance counter.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles after a mult/multu start
//   DIV_CYCLES   10  busy cycles after a div/divu start
// PORTS
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high
//   req          in   1   exception/interrupt request from CP0; pipeline flush this cycle
//   d_rs, d_rt   in   5   source regs of D-stage instruction
//   d_tuse_rs    in   2   cycles until D needs rs (0..2; 3 = unused)
//   d_tuse_rt    in   2   same for rt
//   d_is_md      in   1   D instr is mult/div/mfhi/mflo/mthi/mtlo
//   e_write_reg  in   5   E-stage destination (0 = none)
//   e_tnew       in   2   cycles until E result ready (0..2)
//   m_write_reg  in   5   M-stage destination (0 = none)
//   m_tnew       in   2   cycles until M result ready (0..1)
//   e_md_start   in   1   E instr is mult/multu/div/divu
//   e_md_div     in   1   1 = div/divu, 0 = mult/multu (valid with e_md_start)
//   stall        out  1   combinational stall request
//   pc_en        out  1   PC write enable = ~stall
//   ifid_en      out  1   IF/ID write enable = ~stall
//   idex_clear   out  1   insert bubble into ID/EX = stall & ~req
//   md_busy      out  1   registered: MDU operation in progress
//   stall_cnt    out  32  registered: count of stalled cycles
// BEHAVIOUR
//   Reset: md_busy=0, MDU counter=0, state IDLE, stall_cnt=0. Combinational outputs follow inputs.
//   RAW hazard (per source s in {rs,rt}): stall_s = (s!=0) &&
//     ((s==e_write_reg && e_tnew>tuse_s) || (s==m_write_reg && m_tnew>tuse_s)). tuse 3 never stalls.
//   MD hazard: stall_md = d_is_md && (e_md_start || md_busy).
//   stall = stall_rs | stall_rt | stall_md; no register-level dependence on req except below.
//   MDU FSM, states IDLE/BUSY, counter width $clog2(DIV_CYCLES+1):
//     IDLE: e_md_start && !req -> BUSY, cnt <= (e_md_div ? DIV_CYCLES : MULT_CYCLES).
//           e_md_start with req: start cancelled, stay IDLE.
//     BUSY: cnt decrements each cycle; cnt==1 -> IDLE with cnt<=0. md_busy = (state==BUSY).
//     md_busy therefore high exactly N cycles, starting the cycle after the start cycle.
//     req while BUSY: operation already committed, keeps counting to completion.
//     e_md_start while BUSY cannot occur (stall_md holds it in D); if it does, ignore it.
//   stall_cnt: +1 each cycle stall && !req; wraps 0xFFFFFFFF -> 0. Reset clears.
//   Priority: reset > req > stall. req suppresses idex_clear (ID/EX flushes itself on req).
// STRUCTURE
//   Shared macros include: TUSE_NONE=2'd3, MD op encodings, MULT/DIV cycle defaults.
//   One sub-module: md_busy_timer (IDLE/BUSY FSM + down-counter, outputs md_busy).
//   Hazard compare and stall counter live in the top module.
// TESTING
//   1. lw $1 in E (e_tnew=2), D addu uses $1 (tuse 1) -> stall=1, idex_clear=1, pc_en=0; stall_cnt+1.
//   2. D reads $0, E writes $0 with e_tnew=2 -> stall=0.
//   3. mult start, then mflo in D -> stall 1 (start cycle) + 5 busy cycles = 6 stall cycles; then 0.
//   4. div start -> md_busy high exactly 10 cycles; mult/div in D stalled throughout.
//   5. e_md_start with req=1 -> md_busy stays 0 next cycle; idex_clear=0 while req=1.
//   6. reset mid-BUSY (cnt=4) -> next cycle md_busy=0, stall_cnt=0; stall_cnt at 0xFFFFFFFF +1 -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the D->E stall/flush controller.
package pipe_hazard_ctrl_pkg;

    // Tuse value meaning "this source register is not read"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default mult/div busy windows (cycles after the start cycle)
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Multiply/divide unit operation encodings
    typedef enum logic [2:0] {
        MD_OP_NONE  = 3'd0,
        MD_OP_MULT  = 3'd1,
        MD_OP_MULTU = 3'd2,
        MD_OP_DIV   = 3'd3,
        MD_OP_DIVU  = 3'd4,
        MD_OP_MFHI  = 3'd5,
        MD_OP_MFLO  = 3'd6,
        MD_OP_MTHI  = 3'd7
    } md_op_e;

    // Mult/div busy-timer states
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Mult/div busy window: IDLE/BUSY FSM with a down-counter, registered md_busy.
module md_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic e_md_start,
    input  logic e_md_div,
    output logic md_busy
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    md_state_e       state;
    logic [CW-1:0]   cnt;

    // Start a window on an uncancelled start; count down to completion once committed
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (e_md_start && !req) begin
                        state   <= MD_BUSY;
                        cnt     <= e_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt == CW'(1)) begin
                        state   <= MD_IDLE;
                        cnt     <= '0;
                        md_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state   <= MD_IDLE;
                    cnt     <= '0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// D->E boundary stall/flush controller: RAW and mult/div hazards, enables, stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_write_reg,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_write_reg,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        stall,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_clear,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .md_busy    (md_busy)
    );

    // RAW hazard per source: producer in E or M not ready by the time D needs it
    always_comb begin
        stall_rs = (d_rs != '0) && (d_tuse_rs != TUSE_NONE) &&
                   ((d_rs == e_write_reg && e_tnew > d_tuse_rs) ||
                    (d_rs == m_write_reg && m_tnew > d_tuse_rs));
        stall_rt = (d_rt != '0) && (d_tuse_rt != TUSE_NONE) &&
                   ((d_rt == e_write_reg && e_tnew > d_tuse_rt) ||
                    (d_rt == m_write_reg && m_tnew > d_tuse_rt));
        stall_md = d_is_md && (e_md_start || md_busy);
    end

    // Stall request and the pipeline enables it drives; req owns the ID/EX flush
    always_comb begin
        stall      = stall_rs | stall_rt | stall_md;
        pc_en      = ~stall;
        ifid_en    = ~stall;
        idex_clear = stall & ~req;
    end

    // Performance counter of cycles actually lost to stalls (flush cycles excluded)
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && !req) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
